// File: rtl/dmem_access_unit_if.sv
// Pipeline-side request/response bundle of the data-memory access unit.
interface dmem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misaligned;
  logic        resp_oob;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_misaligned, resp_oob
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_misaligned, resp_oob
  );
endinterface

// File: rtl/dmem_access_unit.sv
// Data-memory initiator: byte/half/word loads with extension, read-modify-write
// sub-word stores, and misaligned/out-of-range fault reporting.
module dmem_access_unit #(
  parameter int unsigned DMEM_WORDS = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  dmem_access_unit_if.slave   bus,
  output logic [31:0]         dmem_raddr,
  output logic [31:0]         dmem_waddr,
  output logic                dmem_write_enable,
  output logic [31:0]         dmem_wdata,
  input  logic [31:0]         dmem_rdata
);

  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DMEM_WORDS);

  typedef enum logic [2:0] {IDLE, LOAD, MERGE, WRITE, RESP} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [31:0] resp_rdata_q;
  logic        resp_mis_q;
  logic        resp_oob_q;

  logic        accept;
  logic        req_mis;
  logic        req_oob;
  logic        req_fault;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_data;
  logic [31:0] merged;

  assign accept    = (state_q == IDLE) && bus.req_valid;
  // size 11 decodes as word, hence testing only size[1]
  assign req_mis   = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                     (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00));
  assign req_oob   = (bus.req_addr >= ADDR_LIMIT);
  assign req_fault = req_mis || req_oob;

  always_comb begin
    byte_lane = dmem_rdata[{addr_q[1:0], 3'b000} +: 8];
    half_lane = addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    load_data = dmem_rdata;
    case (size_q)
      2'b00:   load_data = signed_q ? {{24{byte_lane[7]}}, byte_lane}
                                    : {24'h0, byte_lane};
      2'b01:   load_data = signed_q ? {{16{half_lane[15]}}, half_lane}
                                    : {16'h0, half_lane};
      default: load_data = dmem_rdata;
    endcase
  end

  // Lane replacement into the current memory word; wdata_q still holds the raw store data here.
  always_comb begin
    merged = dmem_rdata;
    if (size_q == 2'b00) begin
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end else if (addr_q[1]) begin
      merged[31:16] = wdata_q[15:0];
    end else begin
      merged[15:0] = wdata_q[15:0];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (req_fault)           state_d = RESP;
          else if (!bus.req_we)    state_d = LOAD;
          else if (bus.req_size[1]) state_d = WRITE;
          else                     state_d = MERGE;
        end
      end
      LOAD:    state_d = RESP;
      MERGE:   state_d = WRITE;
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      size_q   <= '0;
      signed_q <= 1'b0;
    end else if (accept) begin
      addr_q   <= bus.req_addr;
      wdata_q  <= bus.req_wdata;
      size_q   <= bus.req_size;
      signed_q <= bus.req_signed;
    end else if (state_q == MERGE) begin
      wdata_q  <= merged;
    end
  end

  // Response fields change only on the edge entering RESP, so they hold between responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_rdata_q <= '0;
      resp_mis_q   <= 1'b0;
      resp_oob_q   <= 1'b0;
    end else if (accept && req_fault) begin
      resp_rdata_q <= '0;
      resp_mis_q   <= req_mis;
      resp_oob_q   <= req_oob;
    end else if (state_q == LOAD) begin
      resp_rdata_q <= load_data;
      resp_mis_q   <= 1'b0;
      resp_oob_q   <= 1'b0;
    end else if (state_q == WRITE) begin
      resp_rdata_q <= '0;
      resp_mis_q   <= 1'b0;
      resp_oob_q   <= 1'b0;
    end
  end

  assign bus.req_ready       = (state_q == IDLE);
  assign bus.resp_valid      = (state_q == RESP);
  assign bus.resp_rdata      = resp_rdata_q;
  assign bus.resp_misaligned = resp_mis_q;
  assign bus.resp_oob        = resp_oob_q;

  assign dmem_raddr        = addr_q;
  assign dmem_waddr        = addr_q;
  assign dmem_wdata        = wdata_q;
  assign dmem_write_enable = (state_q == WRITE);

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed vector bench for dmem_access_unit with a behavioural word-addressed DMEM.
module tb_dmem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] dmem_raddr, dmem_waddr, dmem_wdata, dmem_rdata;
  logic        dmem_write_enable;
  logic [31:0] mem [256];
  int          we_cnt = 0;
  int          total = 0;
  int          bad = 0;

  dmem_access_unit_if bus ();

  dmem_access_unit #(.DMEM_WORDS(256)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .bus               (bus),
    .dmem_raddr        (dmem_raddr),
    .dmem_waddr        (dmem_waddr),
    .dmem_write_enable (dmem_write_enable),
    .dmem_wdata        (dmem_wdata),
    .dmem_rdata        (dmem_rdata)
  );

  always #5 clk = ~clk;

  assign dmem_rdata = mem[dmem_raddr[9:2]];

  always @(posedge clk) begin
    if (dmem_write_enable) begin
      mem[dmem_waddr[9:2]] <= dmem_wdata;
      we_cnt <= we_cnt + 1;
    end
  end

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_mis;
    logic        exp_oob;
    int          exp_lat;
    int          exp_we;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Starts at a negedge with the unit idle; returns one cycle after the response.
  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic mis, output logic oob,
                        output int lat, output int wes);
    int we0;
    we0 = we_cnt;
    bus.req_we     = we;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 12) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    rdata = bus.resp_rdata;
    mis   = bus.resp_misaligned;
    oob   = bus.resp_oob;
    wes   = we_cnt - we0;
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [1:0]  hs_size [3];
  logic        hs_sgn  [3];
  logic [31:0] hs_addr [3];
  logic [31:0] hs_exp  [3];

  task automatic set_load(input int i);
    bus.req_we     = 1'b0;
    bus.req_size   = hs_size[i];
    bus.req_signed = hs_sgn[i];
    bus.req_addr   = hs_addr[i];
    bus.req_wdata  = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic        mis, oob, acc, prev_resp, saw_resp;
    int          lat, wes, idx, nresp, n, we0;

    //             we    size   sgn   addr          wdata         exp_rdata     mis   oob  lat we
    vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 2, 1};
    vecs[1]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 2, 0};
    vecs[2]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'h11223344, 32'h0,        1'b0, 1'b0, 2, 1};
    vecs[3]  = '{1'b1, 2'b00, 1'b0, 32'h0000_0012, 32'h000000AA, 32'h0,        1'b0, 1'b0, 3, 1};
    vecs[4]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,        32'h11AA3344, 1'b0, 1'b0, 2, 0};
    vecs[5]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'h80FF7F01, 32'h0,        1'b0, 1'b0, 2, 1};
    vecs[6]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0011, 32'h0,        32'h0000007F, 1'b0, 1'b0, 2, 0};
    vecs[7]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0012, 32'h0,        32'hFFFFFFFF, 1'b0, 1'b0, 2, 0};
    vecs[8]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0012, 32'h0,        32'h000080FF, 1'b0, 1'b0, 2, 0};
    vecs[9]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0012, 32'h0,        32'hFFFF80FF, 1'b0, 1'b0, 2, 0};
    vecs[10] = '{1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h0,        32'h00000080, 1'b0, 1'b0, 2, 0};
    vecs[11] = '{1'b0, 2'b11, 1'b1, 32'h0000_0010, 32'h0,        32'h80FF7F01, 1'b0, 1'b0, 2, 0};
    vecs[12] = '{1'b1, 2'b10, 1'b0, 32'h0000_0013, 32'h12345678, 32'h0,        1'b1, 1'b0, 1, 0};
    vecs[13] = '{1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0,        32'h0,        1'b0, 1'b1, 1, 0};
    vecs[14] = '{1'b0, 2'b01, 1'b0, 32'h0000_0011, 32'h0,        32'h0,        1'b1, 1'b0, 1, 0};
    vecs[15] = '{1'b1, 2'b01, 1'b0, 32'h0000_0401, 32'hFFFF,     32'h0,        1'b1, 1'b1, 1, 0};
    vecs[16] = '{1'b0, 2'b00, 1'b0, 32'hFFFF_FFFF, 32'h0,        32'h0,        1'b0, 1'b1, 1, 0};
    vecs[17] = '{1'b1, 2'b10, 1'b0, 32'h0000_0014, 32'h0,        32'h0,        1'b0, 1'b0, 2, 1};
    vecs[18] = '{1'b1, 2'b01, 1'b0, 32'h0000_0016, 32'h1234ABCD, 32'h0,        1'b0, 1'b0, 3, 1};
    vecs[19] = '{1'b0, 2'b10, 1'b0, 32'h0000_0014, 32'h0,        32'hABCD0000, 1'b0, 1'b0, 2, 0};
    vecs[20] = '{1'b1, 2'b10, 1'b0, 32'h0000_03FC, 32'hCAFEF00D, 32'h0,        1'b0, 1'b0, 2, 1};
    vecs[21] = '{1'b0, 2'b01, 1'b1, 32'h0000_03FE, 32'h0,        32'hFFFFCAFE, 1'b0, 1'b0, 2, 0};

    hs_size[0] = 2'b10; hs_sgn[0] = 1'b0; hs_addr[0] = 32'h10; hs_exp[0] = 32'h80FF7F01;
    hs_size[1] = 2'b00; hs_sgn[1] = 1'b0; hs_addr[1] = 32'h13; hs_exp[1] = 32'h00000080;
    hs_size[2] = 2'b01; hs_sgn[2] = 1'b1; hs_addr[2] = 32'h10; hs_exp[2] = 32'h00007F01;

    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
    bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    repeat (2) @(negedge clk);
    chk("reset_ready", {31'h0, bus.req_ready}, 32'h1);
    chk("reset_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
    chk("reset_rdata", bus.resp_rdata, 32'h0);
    chk("reset_we", {31'h0, dmem_write_enable}, 32'h0);
    chk("reset_raddr", dmem_raddr, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      do_req(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata,
             rd, mis, oob, lat, wes);
      chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("v%0d_mis", i), {31'h0, mis}, {31'h0, vecs[i].exp_mis});
      chk($sformatf("v%0d_oob", i), {31'h0, oob}, {31'h0, vecs[i].exp_oob});
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("v%0d_we_pulses", i), 32'(wes), 32'(vecs[i].exp_we));
      if (i == 3) chk("rmw_word4", mem[4], 32'h11AA3344);
    end
    chk("mem_word4", mem[4], 32'h80FF7F01);
    chk("mem_word5", mem[5], 32'hABCD0000);

    // Three loads with req_valid held high throughout.
    idx = 0; nresp = 0; prev_resp = 1'b0;
    set_load(0);
    bus.req_valid = 1'b1;
    for (int cyc = 0; cyc < 40 && nresp < 3; cyc++) begin
      acc = bus.req_ready && bus.req_valid;
      @(posedge clk);
      @(negedge clk);
      if (acc) begin
        chk($sformatf("hs_ready_low%0d", idx), {31'h0, bus.req_ready}, 32'h0);
        idx++;
        if (idx < 3) set_load(idx);
        else bus.req_valid = 1'b0;
      end
      if (bus.resp_valid) begin
        chk($sformatf("hs_rdata%0d", nresp), bus.resp_rdata, hs_exp[nresp]);
        chk($sformatf("hs_width%0d", nresp), {31'h0, prev_resp}, 32'h0);
        nresp++;
      end
      prev_resp = bus.resp_valid;
    end
    chk("hs_count", 32'(nresp), 32'd3);
    @(posedge clk);
    @(negedge clk);
    chk("hs_pulse_end", {31'h0, bus.resp_valid}, 32'h0);

    // Reset asserted while a byte store sits in WRITE.
    do_req(1'b1, 2'b10, 1'b0, 32'h18, 32'h55667788, rd, mis, oob, lat, wes);
    bus.req_we = 1'b1; bus.req_size = 2'b00; bus.req_signed = 1'b0;
    bus.req_addr = 32'h19; bus.req_wdata = 32'h99;
    bus.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (n = 0; n < 8 && !dmem_write_enable; n++) @(negedge clk);
    chk("rst_reached_write", {31'h0, dmem_write_enable}, 32'h1);
    we0 = we_cnt;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_we_drop", {31'h0, dmem_write_enable}, 32'h0);
    chk("rst_ready", {31'h0, bus.req_ready}, 32'h1);
    chk("rst_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
    chk("rst_wdata", dmem_wdata, 32'h0);
    chk("rst_waddr", dmem_waddr, 32'h0);
    @(posedge clk);
    #1;
    chk("rst_word_unchanged", mem[6], 32'h55667788);
    chk("rst_no_write", 32'(we_cnt - we0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_resp = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.resp_valid) saw_resp = 1'b1;
    end
    chk("rst_no_resp", {31'h0, saw_resp}, 32'h0);
    do_req(1'b0, 2'b10, 1'b0, 32'h18, 32'h0, rd, mis, oob, lat, wes);
    chk("post_rst_load", rd, 32'h55667788);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
